// File: rtl/pcileech_tlp_tx_arbiter.sv
// pcileech_tlp_tx_arbiter
//
// Round-robin arbiter that moves packed TLPs from NUM_PORTS sources onto the
// 64-bit PCIe core transmit AXI stream. A source with a complete TLP raises
// p_has_data. The arbiter grants it with a one-cycle p_req_data pulse and
// waits up to TIMEOUT cycles for p_valid. It then latches the whole packed
// buffer into a shift register and streams it one 66-bit entry per beat.
//
// Ports
//   clk, rst       PCIe user clock, synchronous active-high reset
//   port_en        per-port enable, looked at only when choosing a new grant
//   p_has_data     source holds a complete TLP
//   p_req_data     one-cycle one-hot grant pulse
//   p_valid        source presents its packed TLP (only the granted bit counts)
//   p_data         packed TLPs, port k at slice k*66*MAX_QW; each entry is
//                  [63:0] data, [64] last, [65] upper DW valid
//   tx_data/keep/last/valid/ready  transmit AXI stream towards the core
//   stat_tlp_cnt   TLPs fully sent (wraps)
//   stat_drop_cnt  timeouts plus malformed drops (saturates)

module pcileech_tlp_tx_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int MAX_QW    = 18,
    parameter int TIMEOUT   = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           port_en,
    input  logic [NUM_PORTS-1:0]           p_has_data,
    output logic [NUM_PORTS-1:0]           p_req_data,
    input  logic [NUM_PORTS-1:0]           p_valid,
    input  logic [NUM_PORTS*66*MAX_QW-1:0] p_data,
    output logic [63:0]                    tx_data,
    output logic [7:0]                     tx_keep,
    output logic                           tx_last,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    output logic [31:0]                    stat_tlp_cnt,
    output logic [15:0]                    stat_drop_cnt
);

    localparam int ENTRY_W = 66;
    localparam int BUF_W   = ENTRY_W * MAX_QW;
    localparam int GW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, SEND} state_t;

    state_t           state;
    logic [GW-1:0]    grant;
    logic [GW-1:0]    last_grant;
    logic [7:0]       wait_cnt;
    logic [BUF_W-1:0] shreg;

    logic [BUF_W-1:0]     slot [NUM_PORTS];
    logic [NUM_PORTS-1:0] eligible;
    logic                 sel_found;
    logic [GW-1:0]        sel_idx;
    logic [GW:0]          cand;

    logic [65:0] cur;
    logic        e_last;
    logic        e_upper;
    logic        beat_ok;

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_slot
        assign slot[k] = p_data[k*BUF_W +: BUF_W];
    end

    assign eligible = p_has_data & port_en;

    // Rotating priority: scan from the port after last_grant, wrapping
    // around. cand is one bit wider so the wrap subtraction never overflows.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = {1'b0, last_grant} + (GW+1)'(i + 1);
            if (cand >= (GW+1)'(NUM_PORTS))
                cand = cand - (GW+1)'(NUM_PORTS);
            if (!sel_found && eligible[cand[GW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[GW-1:0];
            end
        end
    end

    // The beat on the stream is always the lowest entry of the shift
    // register. tx_valid depends only on state and buffer contents, so it
    // never looks at tx_ready. An entry with neither last nor upper set
    // marks a malformed or exhausted buffer.
    assign cur      = shreg[65:0];
    assign e_last   = cur[64];
    assign e_upper  = cur[65];
    assign beat_ok  = e_last | e_upper;
    assign tx_data  = cur[63:0];
    assign tx_last  = e_last;
    assign tx_keep  = (e_last && !e_upper) ? 8'h0F : 8'hFF;
    assign tx_valid = (state == SEND) && beat_ok;

    // Main sequencer. A timeout still leaves last_grant pointing at the stuck
    // port, so the next scan moves past it. The shift register is cleared on
    // every exit from SEND so idle outputs stay quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            grant         <= '0;
            last_grant    <= GW'(NUM_PORTS - 1);
            wait_cnt      <= '0;
            shreg         <= '0;
            p_req_data    <= '0;
            stat_tlp_cnt  <= '0;
            stat_drop_cnt <= '0;
        end else begin
            p_req_data <= '0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant      <= sel_idx;
                        last_grant <= sel_idx;
                        p_req_data <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << sel_idx;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (p_valid[grant]) begin
                        shreg <= slot[grant];
                        state <= SEND;
                    end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        if (stat_drop_cnt != 16'hFFFF)
                            stat_drop_cnt <= stat_drop_cnt + 16'd1;
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                SEND: begin
                    if (!beat_ok) begin
                        shreg <= '0;
                        if (stat_drop_cnt != 16'hFFFF)
                            stat_drop_cnt <= stat_drop_cnt + 16'd1;
                        state <= IDLE;
                    end else if (tx_ready) begin
                        if (e_last) begin
                            shreg        <= '0;
                            stat_tlp_cnt <= stat_tlp_cnt + 32'd1;
                            state        <= IDLE;
                        end else begin
                            shreg <= shreg >> ENTRY_W;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
